// File: rtl/module_secuenciador_mult.sv
// Keypad multiplication sequencer: captures two operands, launches the Booth
// multiplier, supervises completion with a timeout and selects the displayed value.
module module_secuenciador_mult #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_OP         = 99,
  parameter int unsigned MAX_RES        = 9999,
  parameter int unsigned ERR_VALUE      = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        listo_1,
  input  logic        listo_2,
  input  logic [7:0]  num_1,
  input  logic [7:0]  num_2,
  input  logic        conv_error,
  input  logic        mult_done,
  input  logic [15:0] mult_resultado,
  output logic        mult_valid,
  output logic [7:0]  mult_a,
  output logic [7:0]  mult_b,
  output logic [15:0] numero_output,
  output logic        disp_update,
  output logic        busy,
  output logic        error_flag,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_B    = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_SHOW      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]      ERR_V    = 16'(ERR_VALUE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [15:0]      num_q, num_d;
  logic             valid_q, valid_d;
  logic             disp_q, disp_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             bad_a, bad_b, res_ok;

  assign bad_a   = conv_error || (32'(num_1) > MAX_OP);
  assign bad_b   = conv_error || (32'(num_2) > MAX_OP);
  assign res_ok  = (32'(mult_resultado) <= MAX_RES);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    num_d   = num_q;
    disp_d  = 1'b0;

    case (state_q)
      S_IDLE, S_SHOW, S_ERROR: begin
        if (listo_1) begin
          if (!bad_a) begin
            a_d     = num_1;
            num_d   = {8'd0, num_1};
            disp_d  = 1'b1;
            state_d = S_WAIT_B;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_WAIT_B: begin
        // listo_2 takes priority when both operand pulses coincide
        if (listo_2) begin
          if (!bad_b) begin
            b_d     = num_2;
            num_d   = {8'd0, num_2};
            disp_d  = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_ERROR;
          end
        end else if (listo_1) begin
          if (!bad_a) begin
            a_d    = num_1;
            num_d  = {8'd0, num_1};
            disp_d = 1'b1;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // a completion in the timeout cycle still counts as success
        if (mult_done) begin
          if (res_ok) begin
            num_d   = mult_resultado;
            disp_d  = 1'b1;
            state_d = S_SHOW;
          end else begin
            state_d = S_ERROR;
          end
        end else if (cnt_inc == CNT_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // error code is shown once, on entry only
    if (state_d == S_ERROR && state_q != S_ERROR) begin
      num_d  = ERR_V;
      disp_d = 1'b1;
    end

    valid_d = (state_d == S_START);
    busy_d  = (state_d == S_START) || (state_d == S_WAIT_DONE);
    err_d   = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      disp_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign mult_valid    = valid_q;
  assign mult_a        = a_q;
  assign mult_b        = b_q;
  assign numero_output = num_q;
  assign disp_update   = disp_q;
  assign busy          = busy_q;
  assign error_flag    = err_q;
  assign state_dbg     = state_q;

endmodule
